// File: rtl/vga_timing_out.sv
// 640x480@60 VGA timing generator and colour output stage for the objects-mux pipeline.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_out #(
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned H_VIS      = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VIS      = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  redIn,
  input  logic [7:0]  greenIn,
  input  logic [7:0]  blueIn,
  input  logic        testPatternSel,
  output logic [10:0] pixelX,
  output logic [9:0]  pixelY,
  output logic        startOfFrame,
  output logic [7:0]  redOut,
  output logic [7:0]  greenOut,
  output logic [7:0]  blueOut,
  output logic        hSync,
  output logic        vSync,
  output logic        blankN
);

  localparam int unsigned HTot = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_VIS + V_FP + V_SYNC + V_BP;

  if (HTot > 2048) begin : g_bad_htot
    $error("vga_timing_out: horizontal total exceeds 2048");
  end
  if (VTot > 1024) begin : g_bad_vtot
    $error("vga_timing_out: vertical total exceeds 1024");
  end
  if (PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_out: PIPE_DELAY must be 0..7");
  end

  localparam logic [10:0] HVisEnd    = 11'(H_VIS);
  localparam logic [10:0] HSyncStart = 11'(H_VIS + H_FP);
  localparam logic [10:0] HSyncEnd   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] HLast      = 11'(HTot - 1);
  localparam logic [9:0]  VVisEnd    = 10'(V_VIS);
  localparam logic [9:0]  VSyncStart = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VSyncEnd   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0]  VLast      = 10'(VTot - 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign pixelX       = h_cnt_q;
  assign pixelY       = v_cnt_q;
  assign startOfFrame = (h_cnt_q == '0) && (v_cnt_q == '0);

  logic visible, hs_raw, vs_raw;
  assign visible = (h_cnt_q < HVisEnd) && (v_cnt_q < VVisEnd);
  assign hs_raw  = !((h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd));
  assign vs_raw  = !((v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd));

  // Timing flags are delayed to line up with RGB arriving from the object pipeline.
  logic vis_dly, hs_dly, vs_dly;
  if (PIPE_DELAY == 0) begin : g_no_dly
    assign vis_dly = visible;
    assign hs_dly  = hs_raw;
    assign vs_dly  = vs_raw;
  end else begin : g_dly
    logic [PIPE_DELAY-1:0] vis_q, hs_q, vs_q;
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        vis_q <= '0;
        hs_q  <= '1;
        vs_q  <= '1;
      end else begin
        vis_q[0] <= visible;
        hs_q[0]  <= hs_raw;
        vs_q[0]  <= vs_raw;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          vis_q[i] <= vis_q[i-1];
          hs_q[i]  <= hs_q[i-1];
          vs_q[i]  <= vs_q[i-1];
        end
      end
    end
    assign vis_dly = vis_q[PIPE_DELAY-1];
    assign hs_dly  = hs_q[PIPE_DELAY-1];
    assign vs_dly  = vs_q[PIPE_DELAY-1];
  end

  logic [23:0] rgb_d;

`ifdef VGA_TEST_PATTERN_EN
  // Only pixelX[9:7] selects a bar, so only those bits travel down the delay line.
  logic [2:0] bar_dly;
  if (PIPE_DELAY == 0) begin : g_no_bar_dly
    assign bar_dly = h_cnt_q[9:7];
  end else begin : g_bar_dly
    logic [2:0] bar_q [PIPE_DELAY];
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        for (int i = 0; i < PIPE_DELAY; i++) bar_q[i] <= '0;
      end else begin
        bar_q[0] <= h_cnt_q[9:7];
        for (int i = 1; i < PIPE_DELAY; i++) bar_q[i] <= bar_q[i-1];
      end
    end
    assign bar_dly = bar_q[PIPE_DELAY-1];
  end

  // Bars in order white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    rgb_d = {redIn, greenIn, blueIn};
    if (testPatternSel) begin
      rgb_d = {{8{~bar_dly[1]}}, {8{~bar_dly[2]}}, {8{~bar_dly[0]}}};
    end
    if (!vis_dly) rgb_d = '0;
  end
`else
  logic unused_test_pattern_sel;
  assign unused_test_pattern_sel = testPatternSel;

  always_comb begin
    rgb_d = {redIn, greenIn, blueIn};
    if (!vis_dly) rgb_d = '0;
  end
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      redOut   <= '0;
      greenOut <= '0;
      blueOut  <= '0;
      hSync    <= 1'b1;
      vSync    <= 1'b1;
      blankN   <= 1'b0;
    end else begin
      {redOut, greenOut, blueOut} <= rgb_d;
      hSync    <= hs_dly;
      vSync    <= vs_dly;
      blankN   <= vis_dly;
    end
  end

endmodule

// File: tb/tb_vga_timing_out.sv
// Randomized self-checking bench: two instances (PIPE_DELAY 2 and 0) with a short vertical
// frame, compared cycle by cycle against a coordinate/latency reference model.
module tb_vga_timing_out;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 20, VF = 3, VS = 2, VB = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  logic [7:0]  ri2, gi2, bi2, r2, g2, b2;
  logic [7:0]  ri0, gi0, bi0, r0, g0, b0;
  logic        tp2, tp0, sof2, sof0, hs2, hs0, vs2, vs0, bl2, bl0;
  logic [10:0] x2, x0;
  logic [9:0]  y2, y0;

  vga_timing_out #(
    .PIPE_DELAY(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_dut2 (
    .clk(clk), .resetN(resetN), .redIn(ri2), .greenIn(gi2), .blueIn(bi2),
    .testPatternSel(tp2), .pixelX(x2), .pixelY(y2), .startOfFrame(sof2),
    .redOut(r2), .greenOut(g2), .blueOut(b2), .hSync(hs2), .vSync(vs2), .blankN(bl2)
  );

  vga_timing_out #(
    .PIPE_DELAY(0), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_dut0 (
    .clk(clk), .resetN(resetN), .redIn(ri0), .greenIn(gi0), .blueIn(bi0),
    .testPatternSel(tp0), .pixelX(x0), .pixelY(y0), .startOfFrame(sof0),
    .redOut(r0), .greenOut(g0), .blueOut(b0), .hSync(hs0), .vSync(vs0), .blankN(bl0)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int first_hs2, first_hs0, last_sof;
  logic [23:0] hist2 [8];
  logic [23:0] hist0 [8];
  logic        tph2 [8];
  logic        tph0 [8];
  logic [23:0] bars [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_reset(input string nm, input logic [10:0] x, input logic [9:0] y,
                             input logic sof, input logic [23:0] rgb, input logic hs,
                             input logic vs, input logic bl);
    check({nm, "_rst_x"}, 32'(x), 0);
    check({nm, "_rst_y"}, 32'(y), 0);
    check({nm, "_rst_sof"}, 32'(sof), 1);
    check({nm, "_rst_rgb"}, 32'(rgb), 0);
    check({nm, "_rst_hs"}, 32'(hs), 1);
    check({nm, "_rst_vs"}, 32'(vs), 1);
    check({nm, "_rst_bl"}, 32'(bl), 0);
  endtask

  // Reference: coordinate at cycle c is c mod HT on line (c / HT) mod VT; pins show the
  // coordinate from p+1 cycles earlier, with RGB taken from the inputs driven one cycle ago.
  task automatic check_dut(input string nm, input int p, input int c,
                           input logic [10:0] x, input logic [9:0] y, input logic sof,
                           input logic [23:0] rgb, input logic hs, input logic vs,
                           input logic bl, input logic [23:0] hin, input logic tpin);
    int ex, ey, s, sx, sy;
    logic vis, ehs, evs;
    logic [23:0] ergb;
    ex = c % HT;
    ey = (c / HT) % VT;
    check({nm, "_x"}, 32'(x), 32'(ex));
    check({nm, "_y"}, 32'(y), 32'(ey));
    check({nm, "_sof"}, 32'(sof), 32'(ex == 0 && ey == 0));
    s = c - p - 1;
    if (s < 0) begin
      vis = 1'b0; ehs = 1'b1; evs = 1'b1; ergb = '0;
    end else begin
      sx   = s % HT;
      sy   = (s / HT) % VT;
      vis  = (sx < HV) && (sy < VV);
      ehs  = !(sx >= HV + HF && sx < HV + HF + HS);
      evs  = !(sy >= VV + VF && sy < VV + VF + VS);
      ergb = hin;
`ifdef VGA_TEST_PATTERN_EN
      if (tpin) ergb = bars[(sx / 128) % 8];
`else
      if (tpin) ergb = hin;
`endif
      if (!vis) ergb = '0;
    end
    check({nm, "_rgb"}, 32'(rgb), 32'(ergb));
    check({nm, "_hs"}, 32'(hs), 32'(ehs));
    check({nm, "_vs"}, 32'(vs), 32'(evs));
    check({nm, "_bl"}, 32'(bl), 32'(vis));
  endtask

  // Modes rotate: random colours with random bar select, constant white, pixelX alignment.
  task automatic gen(input int p, input int c, output logic [23:0] v, output logic t);
    int ax;
    case ((c / 4000) % 3)
      0: begin
        v = 24'($urandom);
        t = ($urandom_range(0, 3) == 0);
      end
      1: begin
        v = 24'hFFFFFF;
        t = 1'b0;
      end
      default: begin
        ax = (c - p < 0) ? 0 : (c - p) % HT;
        v = {8'(ax), 16'($urandom)};
        t = 1'b0;
      end
    endcase
  endtask

  task automatic run(input int ncyc);
    logic [23:0] v;
    logic t;
    for (int i = 0; i < ncyc; i++) begin
      check_dut("d2", 2, cyc, x2, y2, sof2, {r2, g2, b2}, hs2, vs2, bl2,
                (cyc > 0) ? hist2[(cyc - 1) % 8] : 24'h0, (cyc > 0) ? tph2[(cyc - 1) % 8] : 1'b0);
      check_dut("d0", 0, cyc, x0, y0, sof0, {r0, g0, b0}, hs0, vs0, bl0,
                (cyc > 0) ? hist0[(cyc - 1) % 8] : 24'h0, (cyc > 0) ? tph0[(cyc - 1) % 8] : 1'b0);
      if (hs2 == 1'b0 && first_hs2 < 0) first_hs2 = cyc;
      if (hs0 == 1'b0 && first_hs0 < 0) first_hs0 = cyc;
      if (sof2) begin
        if (last_sof >= 0) check("sof_period", 32'(cyc - last_sof), 32'(FRAME));
        last_sof = cyc;
      end
      gen(2, cyc, v, t);
      {ri2, gi2, bi2} = v;
      tp2 = t;
      hist2[cyc % 8] = v;
      tph2[cyc % 8] = t;
      gen(0, cyc, v, t);
      {ri0, gi0, bi0} = v;
      tp0 = t;
      hist0[cyc % 8] = v;
      tph0[cyc % 8] = t;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_and_run(input int ncyc);
    resetN = 1'b1;
    cyc = 0;
    first_hs2 = -1;
    first_hs0 = -1;
    last_sof = -1;
    run(ncyc);
    check("hs_first_d2", 32'(first_hs2), 32'(HV + HF + 3));
    check("hs_first_d0", 32'(first_hs0), 32'(HV + HF + 1));
  endtask

  initial begin
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    resetN = 1'b0;
    {ri2, gi2, bi2, tp2} = '0;
    {ri0, gi0, bi0, tp0} = '0;
    cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("d2", x2, y2, sof2, {r2, g2, b2}, hs2, vs2, bl2);
    check_reset("d0", x0, y0, sof0, {r0, g0, b0}, hs0, vs0, bl0);

    release_and_run(2 * FRAME + 10 * HT + 300);

    // Asynchronous reset mid-line: pins must drop back before the next clock edge.
    #2 resetN = 1'b0;
    #1;
    check_reset("d2m", x2, y2, sof2, {r2, g2, b2}, hs2, vs2, bl2);
    check_reset("d0m", x0, y0, sof0, {r0, g0, b0}, hs0, vs0, bl0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("d2h", x2, y2, sof2, {r2, g2, b2}, hs2, vs2, bl2);

    release_and_run(3 * HT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
